// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner.
// Shadow-latches the display word once per frame, then walks the four digits.
// Each digit slot is a dark blanking period followed by the lit digit.
module seven_seg_scan #(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        enable,
    input  logic        lzb_en,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  dig_out,
    output logic        frame_tick
);

    localparam int unsigned     CntW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] CntShow = CntW'(BLANK_CYCLES);
    localparam logic [6:0]      SegOff  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic            DpOff   = SEG_ACTIVE_LOW;
    localparam logic [3:0]      DigOff  = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      dig_idx_q, dig_idx_d;
    logic [15:0]     shadow_val_q, shadow_val_d;
    logic [3:0]      shadow_dp_q, shadow_dp_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      dig_en_q, dig_en_d;
    logic            tick_q, tick_d;

    logic [3:0]      nibble;
    logic [3:0]      lz_mask;
    logic [6:0]      seg_raw;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next-state: slot counter, digit index, frame latch, then the registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dig_idx_d    = dig_idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        tick_d       = 1'b0;

        if (!enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            dig_idx_d = '0;
        end else if (state_q == StIdle) begin
            state_d      = StBlank;
            cnt_d        = '0;
            dig_idx_d    = '0;
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
            tick_d       = 1'b1;
        end else begin
            if (cnt_q == CntLast) begin
                cnt_d     = '0;
                dig_idx_d = dig_idx_q + 2'd1;
                // Wrapping back to digit 0 starts a new frame.
                if (dig_idx_q == 2'd3) begin
                    shadow_val_d = value_in;
                    shadow_dp_d  = dp_in;
                    tick_d       = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
            state_d = (cnt_d < CntShow) ? StBlank : StShow;
        end

        // Digit n blanks when it and every digit to its left is zero.
        lz_mask[3] = (shadow_val_d[15:12] == 4'h0);
        lz_mask[2] = lz_mask[3] && (shadow_val_d[11:8] == 4'h0);
        lz_mask[1] = lz_mask[2] && (shadow_val_d[7:4] == 4'h0);
        lz_mask[0] = 1'b0;

        nibble  = shadow_val_d[{dig_idx_d, 2'b00} +: 4];
        seg_raw = (lzb_en && lz_mask[dig_idx_d]) ? 7'h00 : hex_decode(nibble);

        seg_d    = SegOff;
        dp_d     = DpOff;
        dig_en_d = DigOff;
        if (state_d == StShow) begin
            seg_d    = seg_raw ^ {7{SEG_ACTIVE_LOW}};
            dp_d     = shadow_dp_d[dig_idx_d] ^ SEG_ACTIVE_LOW;
            dig_en_d = (4'b0001 << dig_idx_d) ^ {4{DIG_ACTIVE_LOW}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            dig_idx_q    <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= SegOff;
            dp_q         <= DpOff;
            dig_en_q     <= DigOff;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dig_idx_q    <= dig_idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_en_q     <= dig_en_d;
            tick_q       <= tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign dig_out    = dig_en_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with CLK_DIV=8, BLANK_CYCLES=2, active-low outputs.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        enable;
    logic        lzb_en;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  dig_out;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    seven_seg_scan #(
        .CLK_DIV       (8),
        .BLANK_CYCLES  (2),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .enable    (enable),
        .lzb_en    (lzb_en),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .dig_out   (dig_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic        lzb;
        logic        chg;      // change value_in during digit-1 show
        logic [15:0] chg_val;
        logic [27:0] segs;     // {d3,d2,d1,d0} expected seg_out
        logic [3:0]  dpo;      // expected dp_out per digit
    } vec_t;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    vec_t  vecs [6];
    slot_t sb_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] obs();
        return {frame_tick, dig_out, seg_out, dp_out};
    endfunction

    function automatic logic [12:0] dark(input logic t);
        return {t, 4'hF, 7'h7F, 1'b1};
    endfunction

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 40);
        check("frame_wait", {31'd0, frame_tick}, 32'd1);
    endtask

    initial begin
        int         n;
        int         c;
        slot_t      cur;
        logic [3:0] one;

        vecs[0] = '{16'h1234, 4'h0, 1'b0, 1'b1, 16'hABCD,
                    {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vecs[1] = '{16'hABCD, 4'h0, 1'b0, 1'b0, 16'h0000,
                    {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF};
        vecs[2] = '{16'h0050, 4'h0, 1'b1, 1'b0, 16'h0000,
                    {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
        vecs[3] = '{16'h0000, 4'h0, 1'b1, 1'b0, 16'h0000,
                    {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
        vecs[4] = '{16'h0000, 4'b1000, 1'b1, 1'b0, 16'h0000,
                    {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
        vecs[5] = '{16'h8F0E, 4'b0101, 1'b1, 1'b0, 16'h0000,
                    {7'h00, 7'h0E, 7'h40, 7'h06}, 4'b1010};

        reset    = 1'b1;
        enable   = 1'b0;
        lzb_en   = 1'b0;
        value_in = 16'h0000;
        dp_in    = 4'h0;
        cur      = '0;

        // Reset, then idle with enable low.
        repeat (3) step();
        check("reset_state", obs(), dark(1'b0));
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_dark", obs(), dark(1'b0));
        end

        // First frame after enable: tick, 2 dark, 6 lit on digit 0.
        enable = 1'b1;
        step();
        check("start_tick", obs(), dark(1'b1));
        step();
        check("start_blank", obs(), dark(1'b0));
        for (int i = 0; i < 6; i++) begin
            step();
            check("start_show_d0", obs(), {1'b0, 4'b1110, 7'h40, 1'b1});
        end
        step();
        check("start_blank_d1", obs(), dark(1'b0));

        // Table-driven frames; the scoreboard holds the expected lit slots.
        for (int i = 0; i < 6; i++) begin
            value_in = vecs[i].val;
            dp_in    = vecs[i].dp;
            lzb_en   = vecs[i].lzb;
            for (int d = 0; d < 4; d++) begin
                one = 4'b0001 << d;
                sb_q.push_back('{~one, vecs[i].segs[d*7 +: 7], vecs[i].dpo[d]});
            end
            wait_frame(n);
            if (i > 0) check("frame_period", n, 1);
            for (int k = 0; k < 32; k++) begin
                c = k % 8;
                if (k > 0) step();
                if (c == 2) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 32'd0, 32'd1);
                    end else begin
                        cur = sb_q.pop_front();
                    end
                end
                if (c < 2) check("frame_blank", obs(), dark(k == 0));
                else       check("frame_show", obs(), {1'b0, cur.dig, cur.seg, cur.dp});
                if (vecs[i].chg && k == 11) value_in = vecs[i].chg_val;
            end
        end

        // Drop enable mid-show of digit 2, then restart.
        value_in = 16'h0007;
        dp_in    = 4'h0;
        lzb_en   = 1'b0;
        wait_frame(n);
        repeat (20) step();
        check("pre_drop_d2", obs(), {1'b0, 4'b1011, 7'h40, 1'b1});
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("drop_dark", obs(), dark(1'b0));
        end
        enable = 1'b1;
        step();
        check("restart_tick", obs(), dark(1'b1));
        step();
        check("restart_blank", obs(), dark(1'b0));
        step();
        check("restart_show_d0", obs(), {1'b0, 4'b1110, 7'h78, 1'b1});

        // One-cycle reset mid-show of digit 3 with enable held.
        value_in = 16'h0009;
        wait_frame(n);
        repeat (27) step();
        check("pre_reset_d3", obs(), {1'b0, 4'b0111, 7'h40, 1'b1});
        reset = 1'b1;
        step();
        check("reset_dark", obs(), dark(1'b0));
        check("reset_shadow", {16'd0, dut.shadow_val_q}, 32'd0);
        reset    = 1'b0;
        value_in = 16'h0005;
        step();
        check("post_reset_tick", obs(), dark(1'b1));
        step();
        check("post_reset_blank", obs(), dark(1'b0));
        step();
        check("post_reset_show", obs(), {1'b0, 4'b1110, 7'h12, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
